// File: rtl/booth4_seq_mul.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per RUN cycle, valid/ready on both sides.
// Optional macro BOOTH_EARLY_TERM_EN ends RUN once the remaining multiplier bits are pure sign extension.
module booth4_seq_mul #(
   parameter int unsigned WIDTH = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [WIDTH-1:0]            in_a,
   input  logic [WIDTH-1:0]            in_b,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [2*WIDTH-1:0]          out_p,
   output logic [$clog2(WIDTH/2):0]    out_cycles
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam int unsigned ND = WIDTH / 2;
   localparam int unsigned CW = $clog2(ND) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [PW-1:0]    acc;
   logic [CW-1:0]    idx;

   logic [2:0]       trip;
   logic [PW-1:0]    a_ext;
   logic [PW-1:0]    pp;
   logic [PW-1:0]    pp_sh;
   logic             last_digit;

   // Booth digit recode and weighted partial product for the current digit
   always_comb begin
      trip  = 3'({b_q, 1'b0} >> {idx, 1'b0});
      a_ext = PW'($signed(a_q));
      pp    = '0;
      case (trip)
         3'b001, 3'b010: pp = a_ext;
         3'b011:         pp = a_ext << 1;
         3'b100:         pp = -(a_ext << 1);
         3'b101, 3'b110: pp = -a_ext;
         default:        pp = '0;
      endcase
      pp_sh = pp << {idx, 1'b0};
`ifdef BOOTH_EARLY_TERM_EN
      // remaining digits are all zero once b[W-1:2i+1] is a run of sign bits
      last_digit = (idx == CW'(ND - 1)) ||
                   (WIDTH'($signed(b_q) >>> {idx, 1'b1}) == {WIDTH{b_q[WIDTH-1]}});
`else
      last_digit = (idx == CW'(ND - 1));
`endif
   end

   assign out_p = acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         a_q        <= '0;
         b_q        <= '0;
         acc        <= '0;
         idx        <= '0;
         out_cycles <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q      <= in_a;
                  b_q      <= in_b;
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end
            RUN: begin
               acc <= acc + pp_sh;
               idx <= idx + CW'(1);
               if (last_digit) begin
                  out_cycles <= idx + CW'(1);
                  out_valid  <= 1'b1;
                  state      <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               out_valid <= 1'b0;
               in_ready  <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_booth4_seq_mul.sv
// Scoreboard bench for booth4_seq_mul (WIDTH=64): directed products, stalls, busy rejection, reset abort.
module tb_booth4_seq_mul;

   localparam int unsigned W = 64;

   typedef struct {
      logic [127:0] p;
      int           c;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [W-1:0]   in_a;
   logic [W-1:0]   in_b;
   logic           out_valid;
   logic           out_ready;
   logic [2*W-1:0] out_p;
   logic [5:0]     out_cycles;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   int   sink_mode = 0;  // 0: always ready, 1: random stalls, 2: stalled

   booth4_seq_mul #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_p      (out_p),
      .out_cycles (out_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      n_vec++;
      n_fail++;
      $display("FAIL %s: bound expired", name);
   endtask

   // Number of Booth digits the design should spend on multiplier b
   function automatic int exp_cycles(input logic [W-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
      for (int i = 0; i < W / 2; i++) begin
         bit same = 1'b1;
         for (int k = 2 * i + 1; k < W; k++)
            if (b[k] != b[W-1]) same = 1'b0;
         if (same) return i + 1;
      end
      return W / 2;
`else
      return W / 2;
`endif
   endfunction

   // Output sink
   always @(posedge clk) begin
      #1;
      case (sink_mode)
         0:       out_ready = 1'b1;
         1:       out_ready = 1'($urandom_range(0, 1));
         default: out_ready = 1'b0;
      endcase
   end

   // Monitor: pop on the first cycle of each product, check stability while stalled
   logic         prev_valid = 1'b0;
   logic [127:0] held_p;
   logic [5:0]   held_c;
   always @(negedge clk) begin
      if (rst) begin
         prev_valid = 1'b0;
      end else if (out_valid) begin
         if (!prev_valid) begin
            if (exp_q.size() == 0) begin
               fail_now("unexpected_product");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("product", out_p, e.p);
               chk("cycles", 128'(out_cycles), 128'(e.c));
               if (out_cycles < 6'd1 || out_cycles > 6'd32)
                  fail_now("cycles_range");
            end
            held_p = out_p;
            held_c = out_cycles;
         end else begin
            chk("hold_stable", {out_p, 2'b00, out_cycles}, {held_p, 2'b00, held_c});
         end
         prev_valid = !out_ready;
      end else begin
         prev_valid = 1'b0;
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [127:0] p, input bit push);
      int t = 0;
      while (!in_ready && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (!in_ready) fail_now("in_ready_wait");
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (push) exp_q.push_back('{p: p, c: exp_cycles(b)});
   endtask

   task automatic send_ref(input logic [W-1:0] a, input logic [W-1:0] b);
      logic signed [127:0] sa;
      logic signed [127:0] sb;
      sa = $signed(a);
      sb = $signed(b);
      send(a, b, 128'(sa * sb), 1'b1);
   endtask

   initial begin
      int  t;
      bit  hs;
      bit  saw_valid;
      rst      = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_in_ready", 128'(in_ready), 128'(1));
      chk("reset_out_valid", 128'(out_valid), 128'(0));
      chk("reset_out_cycles", 128'(out_cycles), 128'(0));
      chk("reset_acc", out_p, 128'd0);

      // Multiply and hold: 3*5 with a 5-cycle consumer stall
      @(posedge clk); #1;
      sink_mode = 2;
      send(64'd3, 64'd5, 128'd15, 1'b1);
      t = 0;
      while (!out_valid && t < 100) begin @(posedge clk); #1; t++; end
      if (!out_valid) fail_now("hold_wait_valid");
      repeat (4) @(posedge clk);
      sink_mode = 0;
      t = 0;
      while (out_valid && t < 50) begin @(posedge clk); #1; t++; end
      chk("idle_after_handshake", 128'(in_ready), 128'(1));

      // Directed products
      send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b1);
      send(64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
           128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0001, 1'b1);
      send(64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd0, 1'b1);
      send(64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF,
           128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001, 1'b1);
      send(64'h8000_0000_0000_0000, 64'd1,
           128'hFFFF_FFFF_FFFF_FFFF_8000_0000_0000_0000, 1'b1);
      send(64'd123456789, -64'sd987654321, -128'sd121932631112635269, 1'b1);

      // Reset at RUN cycle 10 aborts the product
      send(64'd100, 64'd200, 128'd0, 1'b0);
      repeat (9) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", 128'(in_ready), 128'(1));
      chk("abort_out_valid", 128'(out_valid), 128'(0));
      saw_valid = 1'b0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      chk("abort_no_product", 128'(saw_valid), 128'(0));
      @(posedge clk); #1;
      send(64'd7, -64'sd6, -128'sd42, 1'b1);

      // Busy rejection: in_valid stays high with changing operands
      t = 0;
      while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
      in_valid = 1'b1;
      in_a     = 64'd11;
      in_b     = -64'sd13;
      @(posedge clk); #1;
      exp_q.push_back('{p: -128'sd143, c: exp_cycles(-64'sd13)});
      hs = 1'b0;
      t  = 0;
      while (!hs && t < 100) begin
         in_a = {$urandom, $urandom};
         in_b = {$urandom, $urandom};
         @(negedge clk);
         hs = out_valid && out_ready;
         @(posedge clk); #1;
         t++;
      end
      if (!hs) fail_now("busy_handshake_wait");
      chk("busy_in_ready_after_hs", 128'(in_ready), 128'(1));
      in_a = -64'sd9;
      in_b = 64'd9;
      @(posedge clk); #1;
      exp_q.push_back('{p: -128'sd81, c: exp_cycles(64'd9)});
      chk("busy_second_accepted", 128'(in_ready), 128'(0));
      in_valid = 1'b0;

      // Random pairs with random consumer stalls
      sink_mode = 1;
      for (int i = 0; i < 30; i++) begin
         logic [W-1:0] a;
         logic [W-1:0] b;
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if (i % 3 == 1) b = W'($signed(32'($urandom_range(0, 255)) - 32'd128));
         if (i % 5 == 2) a = W'($signed(32'($urandom_range(0, 15)) - 32'd8));
         send_ref(a, b);
      end

      t = 0;
      while ((exp_q.size() != 0 || out_valid) && t < 2000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("scoreboard_drained", 128'(exp_q.size()), 128'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
